// File: rtl/vga_palette_out_if.sv
// Bus bundle for the VGA palette output stage: the timing and pixel inputs
// coming from the sync stage, the palette write/read-back port, and the
// registered pin-side outputs.
interface vga_palette_out_if #(
  parameter int unsigned CHAN_W = 6
);
  localparam int unsigned ENT_W = 3 * CHAN_W;

  logic              hsync_in;
  logic              vsync_in;
  logic              active_in;
  logic [3:0]        pixel_color4;
  logic              pal_we;
  logic [3:0]        pal_addr;
  logic [ENT_W-1:0]  pal_wdata;
  logic [ENT_W-1:0]  pal_rdata;
  logic [CHAN_W-1:0] red;
  logic [CHAN_W-1:0] green;
  logic [CHAN_W-1:0] blue;
  logic              hsync;
  logic              vsync;
  logic              active;

  // Upstream / host side: drives timing, pixels and palette writes.
  modport master (
    output hsync_in, vsync_in, active_in, pixel_color4,
    output pal_we, pal_addr, pal_wdata,
    input  pal_rdata, red, green, blue, hsync, vsync, active
  );

  // Output stage side.
  modport slave (
    input  hsync_in, vsync_in, active_in, pixel_color4,
    input  pal_we, pal_addr, pal_wdata,
    output pal_rdata, red, green, blue, hsync, vsync, active
  );
endinterface

// File: rtl/vga_palette_out.sv
// VGA/HDMI output stage: 16-entry writable palette lookup, 2-cycle pipeline
// keeping syncs/active aligned with RGB, blanking outside the visible region.
// Optional scanline dimming of odd lines: define VGA_PALETTE_SCANLINE_EN.
module vga_palette_out #(
  parameter int unsigned CHAN_W   = 6,
  parameter bit          SYNC_POL = 1'b0
) (
  input logic               clk_dot4x,
  input logic               rst_n,
  vga_palette_out_if.slave  bus
);

  localparam int unsigned ENT_W = 3 * CHAN_W;
  localparam int unsigned PAL_N = 16;

  // Reset colour of entry idx: idx bits repeated MSB-first across the channel.
  function automatic logic [ENT_W-1:0] default_entry(input logic [3:0] idx);
    logic [CHAN_W-1:0] ch;
    ch = '0;
    for (int unsigned b = 0; b < CHAN_W; b++) begin
      ch[CHAN_W-1-b] = idx[3 - (b % 4)];
    end
    return {ch, ch, ch};
  endfunction

  logic [ENT_W-1:0]  pal_q [PAL_N];
  logic [ENT_W-1:0]  ent1_q;
  logic              hs1_q, vs1_q, act1_q;
  logic [CHAN_W-1:0] red_q, green_q, blue_q;
  logic [CHAN_W-1:0] red_d, green_d, blue_d;
  logic              hsync_q, vsync_q, active_q;
  logic [ENT_W-1:0]  pal_rdata_q;

  // Palette storage: reset reloads the defaults and wins over a write.
  always_ff @(posedge clk_dot4x) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(PAL_N); i++) begin
        pal_q[i] <= default_entry(4'(i));
      end
    end else if (bus.pal_we) begin
      pal_q[bus.pal_addr] <= bus.pal_wdata;
    end
  end

  // Read-back port; sees the pre-write value on a same-cycle write.
  always_ff @(posedge clk_dot4x) begin
    if (!rst_n) pal_rdata_q <= '0;
    else        pal_rdata_q <= pal_q[bus.pal_addr];
  end

  // Stage 1: palette lookup plus sync/active capture.
  always_ff @(posedge clk_dot4x) begin
    if (!rst_n) begin
      ent1_q <= '0;
      hs1_q  <= 1'b1;
      vs1_q  <= 1'b1;
      act1_q <= 1'b0;
    end else begin
      ent1_q <= pal_q[bus.pixel_color4];
      hs1_q  <= bus.hsync_in;
      vs1_q  <= bus.vsync_in;
      act1_q <= bus.active_in;
    end
  end

`ifdef VGA_PALETTE_SCANLINE_EN
  logic parity_q;
  logic hs_fall, vs_fall;

  // Falling edges against the previous sample held in stage 1.
  assign hs_fall = hs1_q & ~bus.hsync_in;
  assign vs_fall = vs1_q & ~bus.vsync_in;

  // Line parity: frame start clears it, each new line toggles it.
  always_ff @(posedge clk_dot4x) begin
    if (!rst_n)       parity_q <= 1'b0;
    else if (vs_fall) parity_q <= 1'b0;
    else if (hs_fall) parity_q <= ~parity_q;
  end
`endif

  // Stage 2 colour: split channels, optional scanline dim, then blank.
  always_comb begin
    red_d   = ent1_q[ENT_W-1 -: CHAN_W];
    green_d = ent1_q[2*CHAN_W-1 -: CHAN_W];
    blue_d  = ent1_q[CHAN_W-1:0];
`ifdef VGA_PALETTE_SCANLINE_EN
    if (parity_q) begin
      red_d   = red_d >> 1;
      green_d = green_d >> 1;
      blue_d  = blue_d >> 1;
    end
`endif
    if (!act1_q) begin
      red_d   = '0;
      green_d = '0;
      blue_d  = '0;
    end
  end

  // Stage 2: registered pin outputs, syncs at the configured polarity.
  always_ff @(posedge clk_dot4x) begin
    if (!rst_n) begin
      red_q    <= '0;
      green_q  <= '0;
      blue_q   <= '0;
      active_q <= 1'b0;
      hsync_q  <= ~SYNC_POL;
      vsync_q  <= ~SYNC_POL;
    end else begin
      red_q    <= red_d;
      green_q  <= green_d;
      blue_q   <= blue_d;
      active_q <= act1_q;
      hsync_q  <= hs1_q ^ SYNC_POL;
      vsync_q  <= vs1_q ^ SYNC_POL;
    end
  end

  assign bus.red       = red_q;
  assign bus.green     = green_q;
  assign bus.blue      = blue_q;
  assign bus.active    = active_q;
  assign bus.hsync     = hsync_q;
  assign bus.vsync     = vsync_q;
  assign bus.pal_rdata = pal_rdata_q;

endmodule

// File: tb/tb_vga_palette_out.sv
// Scoreboard bench for vga_palette_out: directed vectors push hand-computed
// expectations, a monitor pops and compares them as outputs become due.
module tb_vga_palette_out;

`ifdef VGA_PALETTE_SCANLINE_EN
  localparam bit SCAN = 1'b1;
`else
  localparam bit SCAN = 1'b0;
`endif

  typedef struct {
    int         tgt;
    logic [5:0] r, g, b;
    logic       act, hs, vs;
  } vid_t;

  typedef struct {
    int          tgt;
    logic [17:0] val;
  } rd_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n_r = 1'b0;
  logic        hs_r = 1'b1, vs_r = 1'b1, act_r = 1'b0, we_r = 1'b0;
  logic [3:0]  pix_r = 4'h0, addr_r = 4'h0;
  logic [17:0] wd_r = '0;

  vga_palette_out_if #(.CHAN_W(6)) bus0 ();
  vga_palette_out_if #(.CHAN_W(6)) bus1 ();

  assign bus0.hsync_in = hs_r;   assign bus1.hsync_in = hs_r;
  assign bus0.vsync_in = vs_r;   assign bus1.vsync_in = vs_r;
  assign bus0.active_in = act_r; assign bus1.active_in = act_r;
  assign bus0.pixel_color4 = pix_r; assign bus1.pixel_color4 = pix_r;
  assign bus0.pal_we = we_r;     assign bus1.pal_we = we_r;
  assign bus0.pal_addr = addr_r; assign bus1.pal_addr = addr_r;
  assign bus0.pal_wdata = wd_r;  assign bus1.pal_wdata = wd_r;

  vga_palette_out #(.CHAN_W(6), .SYNC_POL(1'b0)) dut0 (
    .clk_dot4x(clk), .rst_n(rst_n_r), .bus(bus0.slave));
  vga_palette_out #(.CHAN_W(6), .SYNC_POL(1'b1)) dut1 (
    .clk_dot4x(clk), .rst_n(rst_n_r), .bus(bus1.slave));

  vid_t vq[$];
  rd_t  rq[$];
  int   edge_cnt = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  // Apply one vector before the next edge and queue what it must produce.
  task automatic vec(input bit rst, input bit hs, input bit vs, input bit act,
                     input logic [3:0] pix, input bit we, input logic [3:0] addr,
                     input logic [17:0] wd, input logic [5:0] er, input logic [5:0] eg,
                     input logic [5:0] eb, input bit dim, input logic [17:0] erd);
    vid_t v;
    rd_t  rd;
    rst_n_r = rst; hs_r = hs; vs_r = vs; act_r = act;
    pix_r = pix; we_r = we; addr_r = addr; wd_r = wd;
    v.tgt = edge_cnt + 2;
    if (!rst) begin
      v.r = 6'h00; v.g = 6'h00; v.b = 6'h00; v.act = 1'b0; v.hs = 1'b1; v.vs = 1'b1;
      if (vq.size() > 0 && vq[vq.size()-1].tgt == edge_cnt + 1) begin
        vq[vq.size()-1] = '{tgt: edge_cnt + 1, r: 6'h00, g: 6'h00, b: 6'h00,
                            act: 1'b0, hs: 1'b1, vs: 1'b1};
      end
    end else begin
      v.r = (dim && SCAN) ? (er >> 1) : er;
      v.g = (dim && SCAN) ? (eg >> 1) : eg;
      v.b = (dim && SCAN) ? (eb >> 1) : eb;
      v.act = act; v.hs = hs; v.vs = vs;
    end
    vq.push_back(v);
    rd.tgt = edge_cnt + 1;
    rd.val = erd;
    rq.push_back(rd);
    @(negedge clk);
  endtask

  // Monitor: compare every expectation that falls due on this edge.
  initial begin
    vid_t v;
    rd_t  rd;
    logic [22:0] got, exp;
    forever begin
      @(posedge clk);
      #1;
      edge_cnt++;
      while (vq.size() > 0 && vq[0].tgt <= edge_cnt) begin
        v = vq.pop_front();
        exp = {v.r, v.g, v.b, v.act, v.hs, v.vs};
        got = {bus0.red, bus0.green, bus0.blue, bus0.active, bus0.hsync, bus0.vsync};
        n_tests++;
        if (got !== exp || v.tgt != edge_cnt) begin
          n_fail++;
          $display("FAIL video0 edge %0d: got %h required %h", edge_cnt, got, exp);
        end
        got = {bus1.red, bus1.green, bus1.blue, bus1.active, ~bus1.hsync, ~bus1.vsync};
        n_tests++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL video1_pol edge %0d: got %h required %h (syncs shown re-inverted)",
                   edge_cnt, got, exp);
        end
      end
      while (rq.size() > 0 && rq[0].tgt <= edge_cnt) begin
        rd = rq.pop_front();
        n_tests++;
        if (bus0.pal_rdata !== rd.val || rd.tgt != edge_cnt) begin
          n_fail++;
          $display("FAIL pal_rdata edge %0d: got %h required %h", edge_cnt, bus0.pal_rdata, rd.val);
        end
      end
    end
  end

  // Directed stimulus: rst hs vs act pix we addr wdata | r g b dim rdata
  initial begin
    @(negedge clk);
    repeat (3) vec(0, 1, 1, 0, 4'h0, 0, 4'h5, 18'h0, 6'h00, 6'h00, 6'h00, 0, 18'h00000);
    vec(1, 1, 1, 0, 4'h0, 0, 4'h5, 18'h0, 6'h00, 6'h00, 6'h00, 0, 18'h15555);
    // latency and lookup
    vec(1, 1, 1, 1, 4'hF, 0, 4'hF, 18'h0, 6'h3F, 6'h3F, 6'h3F, 0, 18'h3FFFF);
    vec(1, 1, 1, 1, 4'h5, 0, 4'h0, 18'h0, 6'h15, 6'h15, 6'h15, 0, 18'h00000);
    // blanking with a 2-cycle hsync pulse and a vsync pulse
    vec(1, 0, 1, 0, 4'hF, 0, 4'h0, 18'h0, 6'h00, 6'h00, 6'h00, 0, 18'h00000);
    vec(1, 0, 0, 0, 4'hF, 0, 4'h0, 18'h0, 6'h00, 6'h00, 6'h00, 0, 18'h00000);
    vec(1, 1, 0, 0, 4'hF, 0, 4'h0, 18'h0, 6'h00, 6'h00, 6'h00, 0, 18'h00000);
    vec(1, 1, 1, 0, 4'hF, 0, 4'h0, 18'h0, 6'h00, 6'h00, 6'h00, 0, 18'h00000);
    // write collision on entry 3
    vec(1, 1, 1, 1, 4'h3, 1, 4'h3, 18'h3F000, 6'h0C, 6'h0C, 6'h0C, 0, 18'h0C30C);
    vec(1, 1, 1, 1, 4'h3, 0, 4'h3, 18'h0, 6'h3F, 6'h00, 6'h00, 0, 18'h3F000);
    // scanlines: frame start, then three lines
    vec(1, 1, 0, 0, 4'hF, 0, 4'hF, 18'h0, 6'h00, 6'h00, 6'h00, 0, 18'h3FFFF);
    vec(1, 1, 1, 0, 4'hF, 0, 4'hF, 18'h0, 6'h00, 6'h00, 6'h00, 0, 18'h3FFFF);
    vec(1, 1, 1, 1, 4'hF, 0, 4'hF, 18'h0, 6'h3F, 6'h3F, 6'h3F, 0, 18'h3FFFF);
    vec(1, 0, 1, 0, 4'hF, 0, 4'hF, 18'h0, 6'h00, 6'h00, 6'h00, 0, 18'h3FFFF);
    vec(1, 1, 1, 0, 4'hF, 0, 4'hF, 18'h0, 6'h00, 6'h00, 6'h00, 0, 18'h3FFFF);
    vec(1, 1, 1, 1, 4'hF, 0, 4'hF, 18'h0, 6'h3F, 6'h3F, 6'h3F, 1, 18'h3FFFF);
    vec(1, 1, 1, 1, 4'h3, 0, 4'h3, 18'h0, 6'h3F, 6'h00, 6'h00, 1, 18'h3F000);
    vec(1, 0, 1, 0, 4'hF, 0, 4'h3, 18'h0, 6'h00, 6'h00, 6'h00, 0, 18'h3F000);
    vec(1, 1, 1, 0, 4'hF, 0, 4'h3, 18'h0, 6'h00, 6'h00, 6'h00, 0, 18'h3F000);
    vec(1, 1, 1, 1, 4'hF, 0, 4'h3, 18'h0, 6'h3F, 6'h3F, 6'h3F, 0, 18'h3F000);
    // simultaneous hsync/vsync fall: clear wins over toggle
    vec(1, 0, 0, 0, 4'hF, 0, 4'h3, 18'h0, 6'h00, 6'h00, 6'h00, 0, 18'h3F000);
    vec(1, 1, 1, 0, 4'hF, 0, 4'h3, 18'h0, 6'h00, 6'h00, 6'h00, 0, 18'h3F000);
    vec(1, 1, 1, 1, 4'hF, 0, 4'h3, 18'h0, 6'h3F, 6'h3F, 6'h3F, 0, 18'h3F000);
    // mid-line reset while entry 3 is in use, with a competing write
    vec(1, 1, 1, 1, 4'h3, 0, 4'h3, 18'h0, 6'h3F, 6'h00, 6'h00, 0, 18'h3F000);
    vec(0, 1, 1, 1, 4'h3, 1, 4'h3, 18'h00FFF, 6'h00, 6'h00, 6'h00, 0, 18'h00000);
    vec(1, 1, 1, 1, 4'h3, 0, 4'h3, 18'h0, 6'h0C, 6'h0C, 6'h0C, 0, 18'h0C30C);
    vec(1, 1, 1, 1, 4'h0, 0, 4'h0, 18'h0, 6'h00, 6'h00, 6'h00, 0, 18'h00000);
    vec(1, 1, 1, 0, 4'h0, 0, 4'h0, 18'h0, 6'h00, 6'h00, 6'h00, 0, 18'h00000);
    // drain with a bounded wait
    for (int i = 0; i < 6 && (vq.size() > 0 || rq.size() > 0); i++) @(negedge clk);
    if (vq.size() > 0 || rq.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d video and %0d rdata expectations left, required 0",
               vq.size(), rq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
